fft_frame_reader: RTL and testbench
===================================

Name: fft_frame_reader

Overview:
- Captures one complete FFT output frame from the FFT core's streaming source (valid/sop/eop) into an on-chip buffer.
- Exposes that frame and its status registers to the NIOS CPU through a simple memory-mapped slave with 1-cycle read latency.
- Sits between the FFT core output and the NIOS data bus; both sides run on fft_clk.
- Software arms a capture, polls or waits for DONE, then reads the bins.

Parameters:
- DATA_W, 16, width of each real and imaginary component.
- FRAME_LEN, 1024, buffer depth in complex samples; must be a power of two.
- IDX_W, 10, log2(FRAME_LEN).
- STALL_ON_DONE, 0, when 1 snk_ready is deasserted in the DONE state; when 0 samples are discarded instead.

Ports:
- fft_clk  in  1  single clock; all logic is synchronous to it.
- reset_n  in  1  asynchronous active-low reset.
- snk_valid  in  1  FFT sample valid.
- snk_sop  in  1  first sample of a frame; qualified by snk_valid.
- snk_eop  in  1  last sample of a frame; qualified by snk_valid.
- snk_real  in  DATA_W  real component.
- snk_imag  in  DATA_W  imaginary component.
- snk_ready  out  1  sample accepted when snk_valid && snk_ready.
- mm_address  in  IDX_W+1  MSB=1 selects the buffer window; MSB=0 selects registers.
- mm_read  in  1  read strobe.
- mm_write  in  1  write strobe.
- mm_writedata  in  32  write data.
- mm_readdata  out  2*DATA_W  read data, valid the cycle after mm_read.
- mm_readdatavalid  out  1  one-cycle pulse, registered version of mm_read.

Behaviour:
- Reset values: snk_ready=1, mm_readdata=0, mm_readdatavalid=0; state IDLE; all status flags and count cleared. Buffer contents are not reset.
- Registers (MSB=0, low bits):
  - 0 CTRL: write bit0=1 arms, write bit1=1 clears flags. Reads return 0.
  - 1 STATUS, read-only: bit0 DONE, bit1 OVERFLOW, bit2 SHORT, bit3 RESYNC, bit4 ARMED.
  - 2 COUNT, read-only: samples captured in the last frame, 0..FRAME_LEN.
  - Other register addresses read 0.
- Buffer window (MSB=1): reads word {real,imag} at index address[IDX_W-1:0]. Writes are ignored.
- FSM:
  - IDLE: samples accepted and discarded. Arm -> WAIT_SOP; clears DONE/OVERFLOW/SHORT/RESYNC and COUNT.
  - WAIT_SOP: accepted sample with sop -> store at index 0, COUNT=1, go to CAPTURE. An accepted sample with sop && eop -> COUNT=1, SHORT=1, go to DONE. Non-sop samples are discarded.
  - CAPTURE: each accepted sample is written at index COUNT and COUNT increments.
    - eop with COUNT+1==FRAME_LEN -> DONE.
    - eop with COUNT+1<FRAME_LEN -> SHORT=1, DONE.
    - Once COUNT==FRAME_LEN without eop: OVERFLOW=1, further samples are not written, COUNT saturates, and the block stays in CAPTURE until eop -> DONE.
    - sop mid-frame: RESYNC=1, sample stored at index 0, COUNT=1, stay in CAPTURE.
  - DONE: DONE=1. snk_ready=0 if STALL_ON_DONE, else samples are discarded. Arm -> WAIT_SOP with flags cleared.
- Arm while in WAIT_SOP or CAPTURE is ignored. A clear-flags write in the same cycle as arm is a no-op beyond the arm.
- ARMED = state is WAIT_SOP or CAPTURE.
- A buffer read during CAPTURE returns the current memory contents; a same-cycle write to the same index returns old data (read-before-write).
- mm_read and mm_write in the same cycle: the write takes effect and the read returns pre-write register values.
- reset_n asserted mid-capture returns the block to IDLE immediately; outputs take their reset values.

Optional Feature:
- Macro FFT_FRAME_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit).
  - Adds register 3 IRQ_EN: bit0 R/W, reset 0.
  - irq = DONE && IRQ_EN, registered; it drops the cycle after a clear-flags write or an arm.
- Undefined: no irq port and no IRQ_EN register; address 3 reads 0.

Decomposition:
- Package fft_reader_pkg holds:
  - FSM state enum: IDLE, WAIT_SOP, CAPTURE, DONE.
  - Register offset constants: REG_CTRL=0, REG_STATUS=1, REG_COUNT=2, REG_IRQ_EN=3.
  - STATUS bit-position constants.
  - CTRL bit constants: CTRL_ARM=0, CTRL_CLR=1.
- One sub-module, fft_frame_ram: simple dual-port RAM with one write port and one registered read port, FRAME_LEN x 2*DATA_W, read-before-write.

Test Plan:
- Normal frame: reset, arm, then 1024 samples with real=i, imag=-i, sop at i=0, eop at i=1023. Expect STATUS=0x01, COUNT=1024, buffer[5] reads {16'h0005,16'hFFFB}, mm_readdatavalid exactly 1 cycle after mm_read.
- Short frame: arm, send 100 samples with eop on the 100th. Expect STATUS=0x05 and COUNT=100; buffer[99] holds the 100th sample.
- Overflow: arm, send 1030 samples with no eop, then eop on the 1031st. Expect STATUS=0x03, COUNT=1024, buffer[1023] = sample 1023.
- Resync plus pre-arm discard:
  - Send 20 samples before arming; arm; sop at sample 0, second sop at sample 300, eop after 1024 more samples.
  - Expect STATUS=0x09, COUNT=1024, buffer[0] = the second sop sample.
- Stall and reset: with STALL_ON_DONE=1, complete a frame, then hold snk_valid=1. Expect snk_ready=0 until arm. Then arm, pull reset_n low mid-capture. Expect STATUS=0x00, COUNT=0, snk_ready=1.
- FFT_FRAME_IRQ_EN defined: write IRQ_EN=1, complete a frame. Expect irq=1 one cycle after DONE rises; write CTRL=0x2 and expect irq=0 the next cycle.

Source files
------------

// File: rtl/fft_frame_reader_pkg.sv
// fft_reader_pkg: FSM states, register map and bit positions for the FFT frame reader.
// Optional macro FFT_FRAME_IRQ_EN enables the IRQ_EN register at REG_IRQ_EN.
package fft_reader_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOP = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_COUNT  = 2;
  localparam int REG_IRQ_EN = 3;

  localparam int STAT_DONE   = 0;
  localparam int STAT_OVF    = 1;
  localparam int STAT_SHORT  = 2;
  localparam int STAT_RESYNC = 3;
  localparam int STAT_ARMED  = 4;

  localparam int CTRL_ARM = 0;
  localparam int CTRL_CLR = 1;

endpackage

// File: rtl/fft_frame_reader_if.sv
// fft_frame_reader_if: FFT sample stream plus memory-mapped CPU slave bus.
// slave = the frame reader, master = FFT source and CPU side.
interface fft_frame_reader_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 10
);
  logic                  snk_valid;
  logic                  snk_sop;
  logic                  snk_eop;
  logic [DATA_W-1:0]     snk_real;
  logic [DATA_W-1:0]     snk_imag;
  logic                  snk_ready;

  logic [IDX_W:0]        mm_address;
  logic                  mm_read;
  logic                  mm_write;
  logic [31:0]           mm_writedata;
  logic [2*DATA_W-1:0]   mm_readdata;
  logic                  mm_readdatavalid;

  modport slave (
    input  snk_valid, snk_sop, snk_eop,
    input  snk_real, snk_imag,
    output snk_ready,
    input  mm_address, mm_read, mm_write,
    input  mm_writedata,
    output mm_readdata, mm_readdatavalid
  );

  modport master (
    output snk_valid, snk_sop, snk_eop,
    output snk_real, snk_imag,
    input  snk_ready,
    output mm_address, mm_read, mm_write,
    output mm_writedata,
    input  mm_readdata, mm_readdatavalid
  );

endinterface

// File: rtl/fft_frame_reader_ram.sv
// fft_frame_ram: one write port, one registered read port.
// A read and write to the same index in one cycle returns the old word.
module fft_frame_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_waddr,
  input  logic [2*DATA_W-1:0] i_wdata,
  input  logic                i_re,
  input  logic [IDX_W-1:0]    i_raddr,
  output logic [2*DATA_W-1:0] o_rdata
);

  logic [2*DATA_W-1:0] r_mem [DEPTH];
  logic [2*DATA_W-1:0] r_q;

  // Sample write port; contents are never reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port, sees the pre-write word.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/fft_frame_reader.sv
// fft_frame_reader: captures one FFT output frame and exposes it to the CPU.
// Optional macro FFT_FRAME_IRQ_EN adds the irq output and IRQ_EN register.
module fft_frame_reader
  import fft_reader_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int FRAME_LEN     = 1024,
  parameter int IDX_W         = 10,
  parameter int STALL_ON_DONE = 0
) (
  input  logic fft_clk,
  input  logic reset_n,
`ifdef FFT_FRAME_IRQ_EN
  output logic irq,
`endif
  fft_frame_reader_if.slave bus
);

  localparam int RW = 2 * DATA_W;
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(FRAME_LEN);
  localparam logic [IDX_W:0] ONE  = (IDX_W+1)'(1);

  state_e           r_state;
  state_e           w_state_nx;
  logic [IDX_W:0]   r_count;
  logic [IDX_W:0]   w_count_nx;
  logic [IDX_W:0]   w_cnt_inc;

  logic r_done;
  logic r_ovf;
  logic r_short;
  logic r_resync;
  logic w_done_nx;
  logic w_ovf_nx;
  logic w_short_nx;
  logic w_resync_nx;

  logic w_acc;
  logic w_armed;
  logic w_reg_sel;
  logic w_is_ctrl;
  logic w_is_status;
  logic w_is_count;
  logic w_ctrl_wr;
  logic w_arm;
  logic w_clr;
  logic [IDX_W-1:0] w_roff;

  logic             w_we;
  logic [IDX_W-1:0] w_waddr;
  logic [RW-1:0]    w_wdata;
  logic             w_re;
  logic [RW-1:0]    w_ram_q;

  logic [RW-1:0]    w_reg_rdata;
  logic [RW-1:0]    r_reg_rdata;
  logic             r_rd_buf;
  logic             r_rdv;

  logic             w_unused;

`ifdef FFT_FRAME_IRQ_EN
  logic w_is_irqen;
  logic r_irq_en;
  logic r_irq;
`endif

  assign bus.snk_ready =
    !((STALL_ON_DONE != 0) && (r_state == DONE));

  assign w_acc     = bus.snk_valid && bus.snk_ready;
  assign w_armed   = (r_state == WAIT_SOP) ||
                     (r_state == CAPTURE);
  assign w_cnt_inc = r_count + ONE;
  assign w_wdata   = {bus.snk_real, bus.snk_imag};

  assign w_reg_sel   = !bus.mm_address[IDX_W];
  assign w_roff      = bus.mm_address[IDX_W-1:0];
  assign w_is_ctrl   = w_reg_sel &&
                       (w_roff == IDX_W'(REG_CTRL));
  assign w_is_status = w_reg_sel &&
                       (w_roff == IDX_W'(REG_STATUS));
  assign w_is_count  = w_reg_sel &&
                       (w_roff == IDX_W'(REG_COUNT));
`ifdef FFT_FRAME_IRQ_EN
  assign w_is_irqen  = w_reg_sel &&
                       (w_roff == IDX_W'(REG_IRQ_EN));
`endif

  assign w_ctrl_wr = bus.mm_write && w_is_ctrl;
  assign w_arm     = w_ctrl_wr &&
                     bus.mm_writedata[CTRL_ARM] &&
                     !w_armed;
  // Arm already clears flags, so a combined write is just an arm.
  assign w_clr     = w_ctrl_wr &&
                     bus.mm_writedata[CTRL_CLR] &&
                     !bus.mm_writedata[CTRL_ARM];

  assign w_unused = ^bus.mm_writedata;

  // Capture FSM: next state, count, flags and buffer write.
  always_comb begin
    w_state_nx  = r_state;
    w_count_nx  = r_count;
    w_done_nx   = r_done;
    w_ovf_nx    = r_ovf;
    w_short_nx  = r_short;
    w_resync_nx = r_resync;
    w_we        = 1'b0;
    w_waddr     = '0;
    if (w_clr) begin
      w_done_nx   = 1'b0;
      w_ovf_nx    = 1'b0;
      w_short_nx  = 1'b0;
      w_resync_nx = 1'b0;
    end
    unique case (r_state)
      IDLE, DONE: begin
        if (w_arm) begin
          w_state_nx  = WAIT_SOP;
          w_count_nx  = '0;
          w_done_nx   = 1'b0;
          w_ovf_nx    = 1'b0;
          w_short_nx  = 1'b0;
          w_resync_nx = 1'b0;
        end
      end
      WAIT_SOP: begin
        if (w_acc && bus.snk_sop) begin
          w_we       = 1'b1;
          w_count_nx = ONE;
          if (bus.snk_eop) begin
            w_state_nx = DONE;
            w_done_nx  = 1'b1;
            w_short_nx = (FULL != ONE);
          end else begin
            w_state_nx = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (w_acc) begin
          if (bus.snk_sop) begin
            w_resync_nx = 1'b1;
            w_we        = 1'b1;
            w_count_nx  = ONE;
          end else if (r_count != FULL) begin
            w_we       = 1'b1;
            w_waddr    = r_count[IDX_W-1:0];
            w_count_nx = w_cnt_inc;
            if (!bus.snk_eop && (w_cnt_inc == FULL)) begin
              w_ovf_nx = 1'b1;
            end
          end
          if (bus.snk_eop) begin
            w_state_nx = DONE;
            w_done_nx  = 1'b1;
            if (w_count_nx != FULL) begin
              w_short_nx = 1'b1;
            end
          end
        end
      end
    endcase
  end

  // FSM, count and status flag registers.
  always_ff @(posedge fft_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_short  <= 1'b0;
      r_resync <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_count  <= w_count_nx;
      r_done   <= w_done_nx;
      r_ovf    <= w_ovf_nx;
      r_short  <= w_short_nx;
      r_resync <= w_resync_nx;
    end
  end

  // Register file read mux.
  always_comb begin
    w_reg_rdata = '0;
    unique case (1'b1)
      w_is_status: begin
        w_reg_rdata[STAT_DONE]   = r_done;
        w_reg_rdata[STAT_OVF]    = r_ovf;
        w_reg_rdata[STAT_SHORT]  = r_short;
        w_reg_rdata[STAT_RESYNC] = r_resync;
        w_reg_rdata[STAT_ARMED]  = w_armed;
      end
      w_is_count: begin
        w_reg_rdata[IDX_W:0] = r_count;
      end
`ifdef FFT_FRAME_IRQ_EN
      w_is_irqen: begin
        w_reg_rdata[0] = r_irq_en;
      end
`endif
      default: begin
        w_reg_rdata = '0;
      end
    endcase
  end

  // One-cycle read pipeline; remembers which source to return.
  always_ff @(posedge fft_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdv       <= 1'b0;
      r_rd_buf    <= 1'b0;
      r_reg_rdata <= '0;
    end else begin
      r_rdv <= bus.mm_read;
      if (bus.mm_read) begin
        r_rd_buf    <= bus.mm_address[IDX_W];
        r_reg_rdata <= w_reg_rdata;
      end
    end
  end

  assign w_re = bus.mm_read && bus.mm_address[IDX_W];

  assign bus.mm_readdatavalid = r_rdv;
  assign bus.mm_readdata = r_rd_buf ? w_ram_q
                                    : r_reg_rdata;

  fft_frame_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (FRAME_LEN),
    .IDX_W  (IDX_W)
  ) u_ram (
    .i_clk   (fft_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_roff),
    .o_rdata (w_ram_q)
  );

`ifdef FFT_FRAME_IRQ_EN
  // Interrupt enable register and registered level interrupt.
  always_ff @(posedge fft_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (bus.mm_write && w_is_irqen) begin
        r_irq_en <= bus.mm_writedata[0];
      end
      r_irq <= r_done && r_irq_en;
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_fft_frame_reader.sv
// tb_fft_frame_reader: directed vectors for the FFT frame reader.
// Built with STALL_ON_DONE=1; irq checks run when FFT_FRAME_IRQ_EN is set.
module tb_fft_frame_reader;

  logic fft_clk = 1'b0;
  logic reset_n = 1'b1;

  always #5 fft_clk = ~fft_clk;

  fft_frame_reader_if #(.DATA_W(16), .IDX_W(10)) bus ();

`ifdef FFT_FRAME_IRQ_EN
  logic irq;
`endif

  fft_frame_reader #(
    .DATA_W        (16),
    .FRAME_LEN     (1024),
    .IDX_W         (10),
    .STALL_ON_DONE (1)
  ) dut (
    .fft_clk (fft_clk),
    .reset_n (reset_n),
`ifdef FFT_FRAME_IRQ_EN
    .irq     (irq),
`endif
    .bus     (bus)
  );

  typedef struct {
    string       name;
    logic [10:0] addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t vt[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd;

  task automatic tick();
    @(posedge fft_clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mm_wr(logic [10:0] a, logic [31:0] d);
    bus.mm_address   = a;
    bus.mm_writedata = d;
    bus.mm_write     = 1'b1;
    tick();
    bus.mm_write     = 1'b0;
  endtask

  task automatic mm_rd(logic [10:0] a,
                       output logic [31:0] d);
    bus.mm_address = a;
    bus.mm_read    = 1'b1;
    tick();
    bus.mm_read    = 1'b0;
    chk("rdv", 32'(bus.mm_readdatavalid), 32'd1);
    d = bus.mm_readdata;
  endtask

  task automatic add(string n, logic [10:0] a,
                     logic [31:0] e);
    rd_vec_t v;
    v.name = n;
    v.addr = a;
    v.exp  = e;
    vt.push_back(v);
  endtask

  task automatic run_table();
    logic [31:0] d;
    foreach (vt[k]) begin
      mm_rd(vt[k].addr, d);
      chk(vt[k].name, d, vt[k].exp);
    end
    vt.delete();
  endtask

  task automatic send(logic [15:0] re, logic [15:0] im,
                      logic sop, logic eop);
    bus.snk_valid = 1'b1;
    bus.snk_real  = re;
    bus.snk_imag  = im;
    bus.snk_sop   = sop;
    bus.snk_eop   = eop;
    tick();
  endtask

  task automatic idle();
    bus.snk_valid = 1'b0;
    bus.snk_sop   = 1'b0;
    bus.snk_eop   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.snk_valid    = 1'b0;
    bus.snk_sop      = 1'b0;
    bus.snk_eop      = 1'b0;
    bus.snk_real     = '0;
    bus.snk_imag     = '0;
    bus.mm_address   = '0;
    bus.mm_read      = 1'b0;
    bus.mm_write     = 1'b0;
    bus.mm_writedata = '0;

    // Reset values
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.snk_ready), 32'd1);
    chk("rst_rdata", bus.mm_readdata, 32'd0);
    chk("rst_rdv", 32'(bus.mm_readdatavalid), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    add("rst_status", 11'h001, 32'h0);
    add("rst_count",  11'h002, 32'h0);
    add("rst_ctrl",   11'h000, 32'h0);
    add("rst_reg3",   11'h003, 32'h0);
    run_table();

    // Normal frame
    mm_wr(11'h000, 32'h1);
    add("armed", 11'h001, 32'h10);
    run_table();
    for (int i = 0; i < 1024; i++) begin
      send(16'(i), 16'(-i), i == 0, i == 1023);
    end
    idle();

    // Stall in DONE while the source keeps offering data
    bus.snk_valid = 1'b1;
    chk("stall0", 32'(bus.snk_ready), 32'd0);
    tick();
    chk("stall1", 32'(bus.snk_ready), 32'd0);
    mm_wr(11'h405, 32'h12345678);
    add("n_status", 11'h001, 32'h01);
    add("n_count",  11'h002, 32'h400);
    add("n_buf5",   11'h405, 32'h0005FFFB);
    add("n_buf0",   11'h400, 32'h00000000);
    add("n_buf1023", 11'h7FF, 32'h03FFFC01);
    run_table();
    chk("stall2", 32'(bus.snk_ready), 32'd0);

    // readdatavalid is a single-cycle pulse after the read
    tick();
    chk("rdv_pre", 32'(bus.mm_readdatavalid), 32'd0);
    bus.mm_address = 11'h002;
    bus.mm_read    = 1'b1;
    tick();
    bus.mm_read    = 1'b0;
    chk("rdv_one", 32'(bus.mm_readdatavalid), 32'd1);
    chk("rdv_data", bus.mm_readdata, 32'h400);
    tick();
    chk("rdv_post", 32'(bus.mm_readdatavalid), 32'd0);

    // Arm releases the stall; non-sop samples are dropped
    mm_wr(11'h000, 32'h1);
    chk("unstall", 32'(bus.snk_ready), 32'd1);
    idle();
`ifdef FFT_FRAME_IRQ_EN
    mm_wr(11'h003, 32'h1);
    add("irq_en", 11'h003, 32'h1);
    run_table();
`endif

    // Short frame, with a read-before-write probe at index 1
    for (int j = 0; j < 100; j++) begin
      if (j == 1) begin
        bus.mm_address = 11'h401;
        bus.mm_read    = 1'b1;
      end
      send(16'(16'h100 + j), 16'(j), j == 0, j == 99);
      if (j == 1) begin
        bus.mm_read = 1'b0;
        chk("rbw", bus.mm_readdata, 32'h0001FFFF);
      end
    end
    idle();
`ifdef FFT_FRAME_IRQ_EN
    chk("irq_lag", 32'(irq), 32'd0);
    tick();
    chk("irq_rise", 32'(irq), 32'd1);
`endif
    add("s_status", 11'h001, 32'h05);
    add("s_count",  11'h002, 32'd100);
    add("s_buf99",  11'h463, 32'h01630063);
    add("s_buf100", 11'h464, 32'h0064FF9C);
    add("s_buf0",   11'h400, 32'h01000000);
    run_table();
    mm_wr(11'h000, 32'h2);
`ifdef FFT_FRAME_IRQ_EN
    tick();
    chk("irq_clr", 32'(irq), 32'd0);
`endif
    add("c_status", 11'h001, 32'h00);
    add("c_count",  11'h002, 32'd100);
    run_table();

    // Overflow, with an ignored arm mid-capture
    mm_wr(11'h000, 32'h1);
    for (int j = 0; j < 1031; j++) begin
      if (j == 500) begin
        bus.mm_address   = 11'h000;
        bus.mm_writedata = 32'h1;
        bus.mm_write     = 1'b1;
      end
      send(16'(16'h1000 + j), 16'(j), j == 0, j == 1030);
      bus.mm_write = 1'b0;
    end
    idle();
    add("o_status",  11'h001, 32'h03);
    add("o_count",   11'h002, 32'h400);
    add("o_buf1023", 11'h7FF, 32'h13FF03FF);
    add("o_buf0",    11'h400, 32'h10000000);
    add("o_buf1000", 11'h7E8, 32'h13E803E8);
    run_table();

    // Resync with samples offered before arming
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      send(16'(16'hEE00 + k), 16'(16'hEE00 + k),
           k == 0, k == 19);
    end
    idle();
    add("p_status", 11'h001, 32'h00);
    add("p_count",  11'h002, 32'h00);
    run_table();
    mm_wr(11'h000, 32'h1);
    for (int j = 0; j < 1324; j++) begin
      send(16'(16'h2000 + j), 16'(j),
           (j == 0) || (j == 300), j == 1323);
    end
    idle();
    add("r_status",  11'h001, 32'h09);
    add("r_count",   11'h002, 32'h400);
    add("r_buf0",    11'h400, 32'h212C012C);
    add("r_buf1",    11'h401, 32'h212D012D);
    add("r_buf1023", 11'h7FF, 32'h252B052B);
    run_table();

    // Reset pulled mid-capture
    mm_wr(11'h000, 32'h1);
    for (int j = 0; j < 50; j++) begin
      send(16'(j), 16'(j), j == 0, 1'b0);
    end
    bus.mm_address = 11'h001;
    bus.mm_read    = 1'b1;
    tick();
    bus.mm_read    = 1'b0;
    chk("cap_status", bus.mm_readdata, 32'h10);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_ready", 32'(bus.snk_ready), 32'd1);
    chk("mr_rdata", bus.mm_readdata, 32'd0);
    chk("mr_rdv", 32'(bus.mm_readdatavalid), 32'd0);
    idle();
    tick();
    reset_n = 1'b1;
    add("mr_status", 11'h001, 32'h00);
    add("mr_count",  11'h002, 32'h00);
    add("mr_reg3",   11'h003, 32'h00);
    run_table();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
